rowbuff_load_ctrl: RTL

Sequencer and arbiter in front of the matrix row buffer.
- Grants one of `NUM_REQ` row-stream requesters ownership of the buffer for one whole matrix.
- Drives the buffer's enable and end-of-data controls one row per cycle, then waits for the buffer's set flag.
- Holds a matrix-valid handshake toward the consumer.
- Steers only control; the requester data mux sits outside and is driven by `grant_idx`.

---
 rtl/rowbuff_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/rowbuff_load_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rowbuff_pkg.sv
// Shared definitions for the matrix row buffer and its load controller:
// controller state encoding, a width helper and default buffer geometry.
package rowbuff_pkg;

  localparam int DEFAULT_COLUMN_SIZE = 64;
  localparam int DEFAULT_DATA_SIZE   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_WAIT_SET,
    ST_HOLD
  } state_t;

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
// The caller registers the result.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    if (enable) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!any && req[wrap_idx(ptr, off)]) begin
          any                        = 1'b1;
          grant[wrap_idx(ptr, off)]  = 1'b1;
          grant_idx                  = wrap_idx(ptr, off);
        end
      end
    end
  end

endmodule

// File: rtl/rowbuff_load_ctrl.sv
// Row buffer load sequencer: grants one requester a whole matrix, paces rows
// into the buffer, then holds a matrix-valid handshake toward the consumer.
module rowbuff_load_ctrl
  import rowbuff_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int COLUMN_SIZE = DEFAULT_COLUMN_SIZE,
  parameter int IDX_W       = clog2(NUM_REQ),
  parameter int CNT_W       = clog2(COLUMN_SIZE) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               buf_enable,
  output logic               buf_dend,
  input  logic               buf_dset,
  output logic               mat_valid,
  input  logic               mat_ready,
  output logic [IDX_W-1:0]   mat_src,
  output logic [CNT_W-1:0]   mat_rows,
  output logic               busy
);

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     row_cnt;
  logic [CNT_W-1:0]     row_cnt_inc;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 xfer;
  logic                 xfer_end;
  logic [IDX_W-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (state == ST_IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Only the owner's valid/last matter; other requesters are ignored in LOAD.
  assign xfer        = (state == ST_LOAD) && req_valid[grant_idx];
  assign row_cnt_inc = row_cnt + CNT_W'(1);
  assign xfer_end    = req_last[grant_idx] || (row_cnt_inc == CNT_W'(COLUMN_SIZE));
  assign next_ptr    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    req_ready  = '0;
    buf_enable = 1'b0;
    buf_dend   = 1'b0;
    case (state)
      ST_LOAD: begin
        req_ready  = grant;
        buf_enable = xfer;
      end
      ST_FLUSH: begin
        buf_enable = 1'b1;
        buf_dend   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      row_cnt   <= '0;
      grant     <= '0;
      grant_idx <= '0;
      mat_valid <= 1'b0;
      mat_src   <= '0;
      mat_rows  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant     <= arb_grant;
            grant_idx <= arb_idx;
            row_cnt   <= '0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            row_cnt <= row_cnt_inc;
            if (xfer_end) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: state <= ST_WAIT_SET;
        ST_WAIT_SET: begin
          if (buf_dset) begin
            mat_valid <= 1'b1;
            mat_src   <= grant_idx;
            mat_rows  <= row_cnt;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mat_ready) begin
            mat_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            grant     <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
